// File: rtl/main_memory_arbiter_pkg.sv
// Shared FSM encodings and requester IDs for the main-memory arbiter.
package main_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    MEMARB_IDLE  = 2'd0,
    MEMARB_ISSUE = 2'd1,
    MEMARB_WAIT  = 2'd2,
    MEMARB_DONE  = 2'd3
  } memarb_state_e;

  localparam logic MEMARB_ID_FETCH = 1'b0;
  localparam logic MEMARB_ID_DATA  = 1'b1;

endpackage

// File: rtl/main_memory_arbiter_if.sv
// Requester/memory bundle for the main-memory arbiter; slave is the arbiter's view,
// master is the side that owns the requesters and the memory.
interface main_memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              busy;
  logic [ADDR_W-1:0] mem_read_address;
  logic [ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_read_data;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
    output if_done, if_rdata, d_done, d_rdata, busy,
           mem_read_address, mem_write_address, mem_write_data, mem_write_enable
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_read_data,
    input  if_done, if_rdata, d_done, d_rdata, busy,
           mem_read_address, mem_write_address, mem_write_data, mem_write_enable
  );

endinterface

// File: rtl/main_memory_arbiter_select.sv
// Combinational winner pick between fetch and data requests.
// MAIN_MEM_ARB_RR_EN selects round-robin on ties; otherwise data always beats fetch.
module mem_arb_select
  import main_memory_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
`ifdef MAIN_MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = if_req | d_req;
    grant_id    = MEMARB_ID_DATA;
    if (if_req && !d_req) begin
      grant_id = MEMARB_ID_FETCH;
    end
`ifdef MAIN_MEM_ARB_RR_EN
    // On a tie the requester that did not win last time goes next.
    else if (if_req && d_req) begin
      grant_id = (last_grant == MEMARB_ID_DATA) ? MEMARB_ID_FETCH : MEMARB_ID_DATA;
    end
`endif
  end

endmodule

// File: rtl/main_memory_arbiter.sv
// Single-port main-memory arbiter: one fetch/data transaction at a time, fixed read latency.
// Optional macro MAIN_MEM_ARB_RR_EN enables round-robin tie breaking.
module main_memory_arbiter
  import main_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  main_memory_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  memarb_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grab;
  logic              capture;
  logic              grant_valid;
  logic              grant_id;
  logic              grant_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;

`ifdef MAIN_MEM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= MEMARB_ID_FETCH;
    end else if (grab) begin
      last_grant <= grant_id;
    end
  end
`endif

  mem_arb_select u_select (
    .if_req      (bus.if_req),
    .d_req       (bus.d_req),
`ifdef MAIN_MEM_ARB_RR_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign win_we   = (grant_id == MEMARB_ID_DATA) && bus.d_we;
  assign win_addr = (grant_id == MEMARB_ID_DATA) ? bus.d_addr : bus.if_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grab    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      MEMARB_IDLE: begin
        if (grant_valid) begin
          grab    = 1'b1;
          state_d = MEMARB_ISSUE;
        end
      end
      MEMARB_ISSUE: begin
        if (we_q) begin
          state_d = MEMARB_DONE;
        end else if (READ_LATENCY > 1) begin
          cnt_d   = CNT_W'(READ_LATENCY - 1);
          state_d = MEMARB_WAIT;
        end else begin
          capture = 1'b1;
          state_d = MEMARB_DONE;
        end
      end
      MEMARB_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Capture on the cycle the countdown hits zero.
        if (cnt_q <= CNT_W'(1)) begin
          capture = 1'b1;
          state_d = MEMARB_DONE;
        end
      end
      MEMARB_DONE: begin
        state_d = MEMARB_IDLE;
      end
      default: state_d = MEMARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEMARB_IDLE;
      cnt_q      <= '0;
      grant_q    <= MEMARB_ID_FETCH;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_addr_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grab) begin
        grant_q <= grant_id;
        we_q    <= win_we;
        addr_q  <= win_addr;
        if (grant_id == MEMARB_ID_DATA) begin
          wdata_q <= bus.d_wdata;
        end
        // The read port only moves for reads, so it never shifts under a store.
        if (!win_we) begin
          rd_addr_q <= win_addr;
        end
      end
      if (capture) begin
        if (grant_q == MEMARB_ID_DATA) begin
          d_rdata_q <= bus.mem_read_data;
        end else begin
          if_rdata_q <= bus.mem_read_data;
        end
      end
    end
  end

  assign bus.busy              = (state_q != MEMARB_IDLE);
  assign bus.if_done           = (state_q == MEMARB_DONE) && (grant_q == MEMARB_ID_FETCH);
  assign bus.d_done            = (state_q == MEMARB_DONE) && (grant_q == MEMARB_ID_DATA);
  assign bus.if_rdata          = if_rdata_q;
  assign bus.d_rdata           = d_rdata_q;
  assign bus.mem_read_address  = rd_addr_q;
  assign bus.mem_write_address = addr_q;
  assign bus.mem_write_data    = wdata_q;
  // Reset in ISSUE must not let a half-issued store reach memory.
  assign bus.mem_write_enable  = (state_q == MEMARB_ISSUE) && we_q && !rst;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter at READ_LATENCY=2 with a one-register memory model.
module tb_main_memory_arbiter;

  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  main_memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  main_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(RL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h40)  return 32'hDEADBEEF;
    if (a == 32'h200) return 32'hCAFEF00D;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Data for an address driven in cycle N is valid in cycle N+1 (latency 2 from ISSUE).
  logic [31:0] mem_q;
  always_ff @(posedge clk) mem_q <= rom(bus.mem_read_address);
  assign bus.mem_read_data = mem_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    for (int c = 0; c < 2; c++) begin
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.mem_write_enable); end
      checks++; if ({bus.if_done, bus.d_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {bus.if_done, bus.d_done}); end
      checks++; if (bus.if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata: got %h want 0", bus.if_rdata); end
      checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_d_rdata: got %h want 0", bus.d_rdata); end
      tick();
    end
  endtask

  task automatic test_tie();
    bus.d_addr = 32'h200; bus.d_we = 0; bus.d_req = 1;
    bus.if_addr = 32'h44; bus.if_req = 1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      checks++; if (bus.d_done !== (c == 3)) begin errors++; $display("FAIL tie_d_done c=%0d: got %b want %b", c, bus.d_done, (c == 3)); end
      checks++; if (bus.if_done !== (c == 7)) begin errors++; $display("FAIL tie_if_done c=%0d: got %b want %b", c, bus.if_done, (c == 7)); end
      if (c == 2) begin
        checks++; if (bus.mem_read_address !== 32'h200) begin errors++; $display("FAIL tie_addr: got %h want 200", bus.mem_read_address); end
      end
      if (c == 3) begin
        checks++; if (bus.d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL tie_d_rdata: got %h want cafef00d", bus.d_rdata); end
        checks++; if (bus.if_rdata !== 32'h0) begin errors++; $display("FAIL tie_if_untouched: got %h want 0", bus.if_rdata); end
        bus.d_req = 0;
      end
      if (c == 7) begin
        checks++; if (bus.if_rdata !== 32'h0044FFBB) begin errors++; $display("FAIL tie_if_rdata: got %h want 0044ffbb", bus.if_rdata); end
        checks++; if (bus.d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL tie_d_untouched: got %h want cafef00d", bus.d_rdata); end
        bus.if_req = 0;
      end
    end
  endtask

  task automatic test_fetch();
    bus.if_addr = 32'h40; bus.if_req = 1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      checks++; if (bus.if_done !== (c == 3)) begin errors++; $display("FAIL fetch_done c=%0d: got %b want %b", c, bus.if_done, (c == 3)); end
      checks++; if (bus.d_done !== 1'b0) begin errors++; $display("FAIL fetch_d_done c=%0d: got %b want 0", c, bus.d_done); end
      checks++; if (bus.mem_read_address !== 32'h40) begin errors++; $display("FAIL fetch_addr c=%0d: got %h want 40", c, bus.mem_read_address); end
      if (c == 3) begin
        checks++; if (bus.if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: got %h want deadbeef", bus.if_rdata); end
        bus.if_req = 0;
      end
    end
    checks++; if (bus.if_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata_hold: got %h want deadbeef", bus.if_rdata); end
  endtask

  task automatic test_store();
    bus.d_addr = 32'h100; bus.d_wdata = 32'h12345678; bus.d_we = 1; bus.d_req = 1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      checks++; if (bus.mem_write_enable !== (c == 1)) begin errors++; $display("FAIL store_we c=%0d: got %b want %b", c, bus.mem_write_enable, (c == 1)); end
      checks++; if (bus.d_done !== (c == 2)) begin errors++; $display("FAIL store_done c=%0d: got %b want %b", c, bus.d_done, (c == 2)); end
      checks++; if (bus.mem_read_address !== 32'h40) begin errors++; $display("FAIL store_rd_addr c=%0d: got %h want 40", c, bus.mem_read_address); end
      if (c == 1) begin
        checks++; if (bus.mem_write_address !== 32'h100) begin errors++; $display("FAIL store_waddr: got %h want 100", bus.mem_write_address); end
        checks++; if (bus.mem_write_data !== 32'h12345678) begin errors++; $display("FAIL store_wdata: got %h want 12345678", bus.mem_write_data); end
      end
      if (c == 2) bus.d_req = 0;
    end
    bus.d_we = 0;
  endtask

  task automatic test_reset_wait();
    bus.d_addr = 32'h300; bus.d_we = 0; bus.d_req = 1;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstw_busy_before: got %b want 1", bus.busy); end
    checks++; if (bus.mem_read_address !== 32'h300) begin errors++; $display("FAIL rstw_addr: got %h want 300", bus.mem_read_address); end
    rst = 1; bus.d_req = 0;
    tick();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstw_busy c=%0d: got %b want 0", c, bus.busy); end
      checks++; if (bus.d_done !== 1'b0) begin errors++; $display("FAIL rstw_d_done c=%0d: got %b want 0", c, bus.d_done); end
      checks++; if (bus.d_rdata !== 32'h0) begin errors++; $display("FAIL rstw_d_rdata c=%0d: got %h want 0", c, bus.d_rdata); end
      tick();
    end
  endtask

  task automatic test_hold4();
    logic exp_d, exp_i;
    rst = 1;
    tick();
    rst = 0;
    bus.d_addr = 32'h200; bus.d_we = 0; bus.d_req = 1;
    bus.if_addr = 32'h44; bus.if_req = 1;
    for (int c = 1; c <= 16; c++) begin
      tick();
`ifdef MAIN_MEM_ARB_RR_EN
      exp_d = (c == 3) || (c == 11);
      exp_i = (c == 7) || (c == 15);
`else
      exp_d = (c % 4 == 3);
      exp_i = 1'b0;
`endif
      checks++; if (bus.d_done !== exp_d) begin errors++; $display("FAIL hold4_d_done c=%0d: got %b want %b", c, bus.d_done, exp_d); end
      checks++; if (bus.if_done !== exp_i) begin errors++; $display("FAIL hold4_if_done c=%0d: got %b want %b", c, bus.if_done, exp_i); end
      if (c == 15) begin
        bus.d_req = 0; bus.if_req = 0;
      end
    end
  endtask

  task automatic test_back_to_back();
    int last_done = 0;
    bus.if_addr = 32'h80; bus.if_req = 1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++; if (bus.if_done !== (c % 4 == 3)) begin errors++; $display("FAIL b2b_done c=%0d: got %b want %b", c, bus.if_done, (c % 4 == 3)); end
      if (bus.if_done === 1'b1) begin
        checks++; if (bus.if_rdata !== 32'h0080FF7F) begin errors++; $display("FAIL b2b_rdata c=%0d: got %h want 0080ff7f", c, bus.if_rdata); end
        if (last_done != 0) begin
          checks++; if (c - last_done != RL + 2) begin errors++; $display("FAIL b2b_gap: got %0d want %0d", c - last_done, RL + 2); end
        end
        last_done = c;
      end
      if (c == 11) bus.if_req = 0;
    end
  endtask

  initial begin
    test_reset();
    test_tie();
    test_fetch();
    test_store();
    test_reset_wait();
    test_hold4();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
